// File: rtl/sd_sector_responder.sv
// sd_sector_responder: target side of the sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*
// sector protocol. Each 512-byte sector moves as 256 x 16-bit words between
// the initiator buffer and a word-wide backing memory (req held until ack).
//
// Optional feature macro: SD_SECTOR_CSUM_EN (adds csum/csum_vld outputs).
//
// Ports:
//   clk_sys, reset      clock, synchronous active-high reset
//   sd_lba, sd_rd, sd_wr  sector request (sampled only in IDLE)
//   sd_ack              high for the whole sector transfer
//   sd_buff_addr/dout/wr  initiator buffer write side (reads from memory)
//   sd_buff_din         initiator buffer read data, 1-cycle RAM latency
//   mem_addr/rd/wr/wdata  backing memory request, held until mem_ack
//   mem_rdata, mem_ack  backing memory response
//   lba_err             sticky out-of-range LBA flag
//   csum, csum_vld      (SD_SECTOR_CSUM_EN) per-sector word sum and strobe
module sd_sector_responder #(
    parameter int unsigned LBA_BITS = 4,
    parameter int unsigned MEM_AW   = LBA_BITS + 8
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [7:0]        sd_buff_addr,
    output logic [15:0]       sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [15:0]       sd_buff_din,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              lba_err
`ifdef SD_SECTOR_CSUM_EN
    ,
    output logic [15:0]       csum,
    output logic              csum_vld
`endif
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACCEPT,
        S_RD_REQ,
        S_RD_PUSH,
        S_WR_ADDR,
        S_WR_WAIT,
        S_WR_CAP,
        S_WR_REQ,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [LBA_BITS-1:0] lba_q, lba_d;
    logic                oor_q, oor_d;
    logic                dir_wr_q, dir_wr_d;
    logic [7:0]          idx_q, idx_d;
    logic [15:0]         data_q, data_d;
    logic                sd_ack_q, sd_ack_d;
    logic [7:0]          sd_buff_addr_q, sd_buff_addr_d;
    logic [15:0]         sd_buff_dout_q, sd_buff_dout_d;
    logic                sd_buff_wr_q, sd_buff_wr_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [15:0]         mem_wdata_q, mem_wdata_d;
    logic                lba_err_q, lba_err_d;
`ifdef SD_SECTOR_CSUM_EN
    logic [15:0]         csum_q, csum_d;
    logic                csum_vld_q, csum_vld_d;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        lba_d          = lba_q;
        oor_d          = oor_q;
        dir_wr_d       = dir_wr_q;
        idx_d          = idx_q;
        data_d         = data_q;
        sd_ack_d       = sd_ack_q;
        sd_buff_addr_d = sd_buff_addr_q;
        sd_buff_dout_d = sd_buff_dout_q;
        sd_buff_wr_d   = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_rd_d       = mem_rd_q;
        mem_wr_d       = mem_wr_q;
        mem_wdata_d    = mem_wdata_q;
        lba_err_d      = lba_err_q;
`ifdef SD_SECTOR_CSUM_EN
        csum_d         = csum_q;
        csum_vld_d     = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (sd_rd || sd_wr) begin
                    lba_d    = sd_lba[LBA_BITS-1:0];
                    oor_d    = (sd_lba >> LBA_BITS) != 32'd0;
                    dir_wr_d = !sd_rd;  // read wins when both are raised
                    if ((sd_lba >> LBA_BITS) != 32'd0) begin
                        lba_err_d = 1'b1;
                    end
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                sd_ack_d = 1'b1;
                idx_d    = 8'd0;
`ifdef SD_SECTOR_CSUM_EN
                csum_d   = 16'd0;
`endif
                if (dir_wr_q) begin
                    state_d = S_WR_ADDR;
                end else begin
                    mem_addr_d = MEM_AW'({lba_q, 8'd0});
                    mem_rd_d   = !oor_q;
                    state_d    = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                // Out-of-range sectors read as zero without touching memory
                if (oor_q) begin
                    data_d  = 16'd0;
                    state_d = S_RD_PUSH;
                end else if (mem_ack && mem_rd_q) begin
                    data_d   = mem_rdata;
                    mem_rd_d = 1'b0;
                    state_d  = S_RD_PUSH;
                end
            end
            S_RD_PUSH: begin
                sd_buff_addr_d = idx_q;
                sd_buff_dout_d = data_q;
                sd_buff_wr_d   = 1'b1;
`ifdef SD_SECTOR_CSUM_EN
                csum_d         = csum_q + data_q;
`endif
                if (idx_q == 8'hFF) begin
                    state_d = S_DONE;
`ifdef SD_SECTOR_CSUM_EN
                    csum_vld_d = 1'b1;
`endif
                end else begin
                    idx_d      = idx_q + 8'd1;
                    mem_addr_d = MEM_AW'({lba_q, idx_q + 8'd1});
                    mem_rd_d   = !oor_q;
                    state_d    = S_RD_REQ;
                end
            end
            S_WR_ADDR: begin
                sd_buff_addr_d = idx_q;
                state_d        = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                // Buffer RAM registers the address on this edge
                state_d = S_WR_CAP;
            end
            S_WR_CAP: begin
                mem_wdata_d = sd_buff_din;
                mem_addr_d  = MEM_AW'({lba_q, idx_q});
                mem_wr_d    = !oor_q;
`ifdef SD_SECTOR_CSUM_EN
                csum_d      = csum_q + sd_buff_din;
`endif
                state_d     = S_WR_REQ;
            end
            S_WR_REQ: begin
                if (oor_q || (mem_ack && mem_wr_q)) begin
                    mem_wr_d = 1'b0;
                    if (idx_q == 8'hFF) begin
                        state_d = S_DONE;
`ifdef SD_SECTOR_CSUM_EN
                        csum_vld_d = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_WR_ADDR;
                    end
                end
            end
            S_DONE: begin
                sd_ack_d       = 1'b0;
                sd_buff_addr_d = 8'd0;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= S_IDLE;
            lba_q          <= '0;
            oor_q          <= 1'b0;
            dir_wr_q       <= 1'b0;
            idx_q          <= 8'd0;
            data_q         <= 16'd0;
            sd_ack_q       <= 1'b0;
            sd_buff_addr_q <= 8'd0;
            sd_buff_dout_q <= 16'd0;
            sd_buff_wr_q   <= 1'b0;
            mem_addr_q     <= '0;
            mem_rd_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_wdata_q    <= 16'd0;
            lba_err_q      <= 1'b0;
`ifdef SD_SECTOR_CSUM_EN
            csum_q         <= 16'd0;
            csum_vld_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            lba_q          <= lba_d;
            oor_q          <= oor_d;
            dir_wr_q       <= dir_wr_d;
            idx_q          <= idx_d;
            data_q         <= data_d;
            sd_ack_q       <= sd_ack_d;
            sd_buff_addr_q <= sd_buff_addr_d;
            sd_buff_dout_q <= sd_buff_dout_d;
            sd_buff_wr_q   <= sd_buff_wr_d;
            mem_addr_q     <= mem_addr_d;
            mem_rd_q       <= mem_rd_d;
            mem_wr_q       <= mem_wr_d;
            mem_wdata_q    <= mem_wdata_d;
            lba_err_q      <= lba_err_d;
`ifdef SD_SECTOR_CSUM_EN
            csum_q         <= csum_d;
            csum_vld_q     <= csum_vld_d;
`endif
        end
    end

    assign sd_ack       = sd_ack_q;
    assign sd_buff_addr = sd_buff_addr_q;
    assign sd_buff_dout = sd_buff_dout_q;
    assign sd_buff_wr   = sd_buff_wr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign mem_wr       = mem_wr_q;
    assign mem_wdata    = mem_wdata_q;
    assign lba_err      = lba_err_q;
`ifdef SD_SECTOR_CSUM_EN
    assign csum         = csum_q;
    assign csum_vld     = csum_vld_q;
`endif

endmodule
